// File: rtl/l2_train_param_if.sv
// Signal bundle between the L2 trainer, the label/event front end and the L2 neuron array.
interface l2_train_param_if #(
  parameter int P_WIDTH = 8,
  parameter int P_NIN   = 6,
  parameter int P_NOUT  = 3
);
  localparam int TH = 2*P_WIDTH + 4;

  // No valid/ready handshake here: inputs are levels sampled every cycle,
  // o_las/o_done are single-cycle pulses, everything else is a plain level.
  logic [P_NOUT-1:0]               i_label;
  logic [P_NOUT-1:0]               i_spike;
  logic [P_NIN*P_WIDTH-1:0]        i_ts;
  logic [P_NOUT*TH-1:0]            i_lv;
  logic                            i_endof_epochs;
  logic [P_NOUT*P_NIN*P_WIDTH-1:0] o_weights;
  logic [P_NOUT*TH-1:0]            o_thresholds;
  logic                            o_las;
  logic                            o_gas;
  logic                            o_done;
  logic [1:0]                      o_state;

  modport master (
    output i_label, i_spike, i_ts, i_lv, i_endof_epochs,
    input  o_weights, o_thresholds, o_las, o_gas, o_done, o_state
  );

  modport slave (
    input  i_label, i_spike, i_ts, i_lv, i_endof_epochs,
    output o_weights, o_thresholds, o_las, o_gas, o_done, o_state
  );
endinterface

// File: rtl/l2_train_param.sv
// Supervised trainer for the ODESA L2 layer: label-opened window, then serial weight/threshold update.
// Optional macro L2T_UNSUP_INC_EN: threshold bump on spikes seen while idle.
module l2_train_param #(
  parameter int P_WIDTH       = 8,
  parameter int P_NIN         = 6,
  parameter int P_NOUT        = 3,
  parameter int P_PASS_CYC    = 6,
  parameter int P_STEP        = 2,
  parameter int P_INC_DELTA   = 'h3f,
  parameter int P_DEFAULT_W   = 'h7f,
  parameter int P_DEFAULT_THR = 'h06000
) (
  input logic             i_clk,
  input logic             i_rst,
  l2_train_param_if.slave bus
);
  localparam int W  = P_WIDTH;
  localparam int TH = 2*W + 4;
  localparam int KW = (P_NOUT > 1) ? $clog2(P_NOUT) : 1;
  localparam int CW = (P_PASS_CYC > 1) ? $clog2(P_PASS_CYC) : 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_WINDOW = 2'd1;
  localparam logic [1:0] S_UPDATE = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam logic [W-1:0]      STEP     = W'(P_STEP);
  localparam logic [W-1:0]      STEP_LIM = {W{1'b1}} - STEP;
  localparam logic [W-1:0]      DEF_W    = W'(P_DEFAULT_W);
  localparam logic [TH-1:0]     DEF_THR  = TH'(P_DEFAULT_THR);
  localparam logic [TH-1:0]     INC2     = TH'(2*P_INC_DELTA);
  localparam logic [CW-1:0]     CNT_LAST = CW'(P_PASS_CYC - 1);
  localparam logic [KW-1:0]     K_LAST   = KW'(P_NOUT - 1);
  localparam logic [P_NOUT-1:0] ONE_N    = P_NOUT'(1);

  function automatic logic [TH-1:0] sat_add(input logic [TH-1:0] a, input logic [TH-1:0] b);
    logic [TH:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[TH] ? {TH{1'b1}} : s[TH-1:0];
  endfunction

  logic [1:0]        state_q, state_d;
  logic [P_NOUT-1:0] lab_q, lab_d;
  logic [P_NOUT-1:0] win_q, win_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [KW-1:0]     k_q, k_d;
  logic [P_NOUT-1:0] spike_q, label_q;
  logic              endof_q;
  logic              las_q, gas_q, done_q;
  logic [W-1:0]      snap_q [P_NIN];
  logic [W-1:0]      w_q    [P_NOUT][P_NIN];
  logic [TH-1:0]     thr_q  [P_NOUT];

  logic [W-1:0]      ts_in [P_NIN];
  logic [TH-1:0]     lv_in [P_NOUT];
  logic [W-1:0]      w_row_d [P_NIN];
  logic [TH-1:0]     thr_upd, thr_cur, thr_delta;
  logic              win_k, lab_k;

  logic [P_NOUT-1:0] spike_rise, spike_first;
  logic              label_rise, label_onehot, label_acc, endof_rise;

  for (genvar j = 0; j < P_NIN; j++) begin : g_ts
    assign ts_in[j] = bus.i_ts[j*W +: W];
  end

  for (genvar k = 0; k < P_NOUT; k++) begin : g_out
    assign lv_in[k]                    = bus.i_lv[k*TH +: TH];
    assign bus.o_thresholds[k*TH +: TH] = thr_q[k];
    for (genvar j = 0; j < P_NIN; j++) begin : g_w
      assign bus.o_weights[(k*P_NIN+j)*W +: W] = w_q[k][j];
    end
  end

  assign spike_rise   = bus.i_spike & ~spike_q;
  // Lowest-index rising spike wins when several rise together.
  assign spike_first  = spike_rise & (~spike_rise + ONE_N);
  assign label_rise   = (|bus.i_label) & ~(|label_q);
  assign label_onehot = ((bus.i_label & (bus.i_label - ONE_N)) == '0);
  assign label_acc    = label_rise & label_onehot & ~bus.i_endof_epochs;
  assign endof_rise   = bus.i_endof_epochs & ~endof_q;

  always_comb begin
    state_d = state_q;
    lab_d   = lab_q;
    win_d   = win_q;
    cnt_d   = cnt_q;
    k_d     = k_q;
    case (state_q)
      S_IDLE: begin
        if (label_acc) begin
          state_d = S_WINDOW;
          lab_d   = bus.i_label;
          win_d   = spike_first;
          cnt_d   = '0;
          k_d     = '0;
        end
      end
      S_WINDOW: begin
        if (endof_rise) begin
          state_d = S_IDLE;
        end else begin
          if (win_q == '0) win_d = spike_first;
          if (cnt_q == CNT_LAST) begin
            state_d = S_UPDATE;
            k_d     = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      S_UPDATE: begin
        if (k_q == K_LAST) state_d = S_DONE;
        else               k_d     = k_q + KW'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      lab_q   <= '0;
      win_q   <= '0;
      cnt_q   <= '0;
      k_q     <= '0;
      spike_q <= '0;
      label_q <= '0;
      endof_q <= 1'b0;
      las_q   <= 1'b0;
      gas_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lab_q   <= lab_d;
      win_q   <= win_d;
      cnt_q   <= cnt_d;
      k_q     <= k_d;
      spike_q <= bus.i_spike;
      label_q <= bus.i_label;
      endof_q <= bus.i_endof_epochs;
      las_q   <= |spike_rise;
      gas_q   <= (state_d == S_WINDOW) || (state_d == S_UPDATE);
      done_q  <= (state_d == S_DONE);
    end
  end

  // The snapshot is frozen only once a window has its winner.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int j = 0; j < P_NIN; j++) snap_q[j] <= '0;
    end else if ((|spike_rise) && !((state_q == S_WINDOW) && (win_q != '0))) begin
      for (int j = 0; j < P_NIN; j++) snap_q[j] <= ts_in[j];
    end
  end

  always_comb begin
    win_k     = win_q[k_q];
    lab_k     = lab_q[k_q];
    thr_cur   = thr_q[k_q];
    thr_upd   = thr_cur;
    thr_delta = TH'(1);
    if      (thr_cur > TH'('hffff)) thr_delta = TH'('h3ff);
    else if (thr_cur > TH'('hfff))  thr_delta = TH'('hff);
    else if (thr_cur > TH'('hff))   thr_delta = TH'('hf);
    for (int j = 0; j < P_NIN; j++) begin
      w_row_d[j] = w_q[k_q][j];
      if (win_k && lab_k) begin
        if ((w_q[k_q][j] < snap_q[j]) && (w_q[k_q][j] <= STEP_LIM))
          w_row_d[j] = w_q[k_q][j] + STEP;
        else if ((w_q[k_q][j] > snap_q[j]) && (w_q[k_q][j] > STEP))
          w_row_d[j] = w_q[k_q][j] - STEP;
      end else if (win_k) begin
        if ((w_q[k_q][j] < snap_q[j]) && (w_q[k_q][j] > STEP))
          w_row_d[j] = w_q[k_q][j] - STEP;
        else if ((w_q[k_q][j] >= snap_q[j]) && (w_q[k_q][j] <= STEP_LIM))
          w_row_d[j] = w_q[k_q][j] + STEP;
      end
    end
    if (win_k && lab_k) begin
      thr_upd = sat_add(thr_cur, INC2);
    end else if (lab_k) begin
      // A missed label decays the threshold; at the floor it reloads from the live level.
      thr_upd = (thr_cur > thr_delta) ? (thr_cur - thr_delta) : lv_in[k_q];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int k = 0; k < P_NOUT; k++) begin
        thr_q[k] <= DEF_THR;
        for (int j = 0; j < P_NIN; j++) w_q[k][j] <= DEF_W;
      end
    end else if (state_q == S_UPDATE) begin
      for (int j = 0; j < P_NIN; j++) w_q[k_q][j] <= w_row_d[j];
      thr_q[k_q] <= thr_upd;
    end
`ifdef L2T_UNSUP_INC_EN
    else if ((state_q == S_IDLE) && !label_acc && !bus.i_endof_epochs) begin
      for (int k = 0; k < P_NOUT; k++)
        if (spike_rise[k]) thr_q[k] <= sat_add(thr_q[k], TH'(P_INC_DELTA));
    end
`endif
  end

  assign bus.o_las   = las_q;
  assign bus.o_gas   = gas_q;
  assign bus.o_done  = done_q;
  assign bus.o_state = state_q;
endmodule

// File: tb/tb_l2_train_param.sv
// Self-checking bench for l2_train_param: directed training scenarios plus a short random run.
module tb_l2_train_param;
  localparam int W    = 8;
  localparam int NIN  = 6;
  localparam int NOUT = 3;
  localparam int TH   = 20;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;

  logic [31:0] exp_q[$];
  string       tag_q[$];
  int          sel_q[$];

  int m_w [NOUT][NIN];
  int m_thr [NOUT];
  int m_ts [NIN];
  int m_lv [NOUT];

  always #5 clk = ~clk;

  l2_train_param_if #(.P_WIDTH(W), .P_NIN(NIN), .P_NOUT(NOUT)) bus ();
  l2_train_param_if #(.P_WIDTH(W), .P_NIN(NIN), .P_NOUT(NOUT)) bus2 ();

  l2_train_param #(.P_WIDTH(W), .P_NIN(NIN), .P_NOUT(NOUT)) u_dut (
    .i_clk(clk), .i_rst(rst), .bus(bus)
  );

  l2_train_param #(.P_WIDTH(W), .P_NIN(NIN), .P_NOUT(NOUT), .P_DEFAULT_THR('h1)) u_dut_floor (
    .i_clk(clk), .i_rst(rst), .bus(bus2)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 'h%0h expected 'h%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] dut_w(input int k, input int j);
    return 32'(bus.o_weights[(k*NIN+j)*W +: W]);
  endfunction

  function automatic logic [31:0] dut_thr(input int k);
    return 32'(bus.o_thresholds[k*TH +: TH]);
  endfunction

  task automatic set_ts_all(input int v);
    for (int j = 0; j < NIN; j++) begin
      m_ts[j] = v;
      bus.i_ts[j*W +: W] = W'(v);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NOUT; k++) begin
      m_thr[k] = 'h06000;
      for (int j = 0; j < NIN; j++) m_w[k][j] = 'h7f;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    model_reset();
  endtask

  // Reference behaviour of one full update sequence, written from the rule table.
  function automatic void model_train(input int lab, input int wn);
    for (int k = 0; k < NOUT; k++) begin
      if (wn == k) begin
        for (int j = 0; j < NIN; j++) begin
          int a = m_w[k][j];
          int b = m_ts[j];
          if (lab == k) begin
            if (a < b && a <= 255 - 2) a = a + 2;
            else if (a > b && a > 2)   a = a - 2;
          end else begin
            if (a < b && a > 2)         a = a - 2;
            else if (a >= b && a <= 253) a = a + 2;
          end
          m_w[k][j] = a;
        end
        if (lab == k) m_thr[k] = (m_thr[k] + 126 > 'hfffff) ? 'hfffff : m_thr[k] + 126;
      end else if (lab == k) begin
        int d;
        d = (m_thr[k] > 'hffff) ? 'h3ff : (m_thr[k] > 'hfff) ? 'hff : (m_thr[k] > 'hff) ? 'hf : 1;
        m_thr[k] = (m_thr[k] > d) ? m_thr[k] - d : m_lv[k];
      end
    end
  endfunction

  task automatic sb_push();
    for (int k = 0; k < NOUT; k++)
      for (int j = 0; j < NIN; j++) begin
        exp_q.push_back(32'(m_w[k][j]));
        tag_q.push_back($sformatf("w%0d_%0d", k, j));
        sel_q.push_back(k*NIN + j);
      end
    for (int k = 0; k < NOUT; k++) begin
      exp_q.push_back(32'(m_thr[k]));
      tag_q.push_back($sformatf("thr%0d", k));
      sel_q.push_back(NOUT*NIN + k);
    end
  endtask

  task automatic sb_drain(input string pre);
    logic [31:0] e, obs;
    string       t;
    int          s;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      s = sel_q.pop_front();
      obs = (s < NOUT*NIN) ? dut_w(s / NIN, s % NIN) : dut_thr(s - NOUT*NIN);
      check_eq({pre, "_", t}, obs, e);
    end
  endtask

  // Label event in cycle t (relative 0); spikes driven at window-relative offsets.
  task automatic do_label(input logic [2:0] lab, input logic [2:0] spk, input int off,
                          input logic [2:0] late_spk, input int late_off, input int late_ts,
                          output int done_cyc);
    int c;
    done_cyc = -1;
    bus.i_label = lab;
    if (off == 0) bus.i_spike = spk;
    tick();
    bus.i_label = '0;
    c = 1;
    check_eq("gas_window", 32'(bus.o_gas), 32'd1);
    while (c < 40) begin
      if (c == off + 1) bus.i_spike = '0;
      if (off > 0 && c == off) bus.i_spike = spk;
      if (late_off > 0 && c == late_off) begin
        bus.i_spike = late_spk;
        if (late_ts >= 0)
          for (int j = 0; j < NIN; j++) bus.i_ts[j*W +: W] = W'(late_ts);
      end
      if (late_off > 0 && c == late_off + 1) bus.i_spike = '0;
      if (bus.o_done) begin
        done_cyc = c;
        break;
      end
      tick();
      c++;
    end
    if (done_cyc < 0) check_eq("done_seen", 32'(bus.o_done), 32'd1);
    bus.i_spike = '0;
    tick();
    check_eq("done_pulse", 32'(bus.o_done), 32'd0);
  endtask

  initial begin
    int dc, lab_i, wn, off, r, cnt_done;
    logic [2:0] spk;

    rst = 1'b1;
    bus.i_label = '0; bus.i_spike = '0; bus.i_ts = '0; bus.i_lv = '0; bus.i_endof_epochs = 1'b0;
    bus2.i_label = '0; bus2.i_spike = '0; bus2.i_ts = '0; bus2.i_lv = '0; bus2.i_endof_epochs = 1'b0;
    for (int k = 0; k < NOUT; k++) m_lv[k] = 0;

    // Reset values
    do_reset();
    sb_push();
    sb_drain("rst");
    check_eq("rst_done", 32'(bus.o_done), 32'd0);
    check_eq("rst_gas", 32'(bus.o_gas), 32'd0);
    check_eq("rst_state", 32'(bus.o_state), 32'd0);

    // Hebbian: label 001, spike[0] at t+2
    do_reset();
    set_ts_all('h90);
    model_train(0, 0);
    sb_push();
    do_label(3'b001, 3'b001, 2, 3'b000, 0, -1, dc);
    check_eq("heb_done_lat", 32'(dc), 32'd10);
    sb_drain("heb");
    check_eq("heb_w0_0", dut_w(0, 0), 32'h81);
    check_eq("heb_thr0", dut_thr(0), 32'h0607e);

    // Wrong winner: label 010, spike[0]
    do_reset();
    set_ts_all('h90);
    model_train(1, 0);
    sb_push();
    do_label(3'b010, 3'b001, 1, 3'b000, 0, -1, dc);
    check_eq("ww_done_lat", 32'(dc), 32'd10);
    sb_drain("ww");
    check_eq("ww_w0_3", dut_w(0, 3), 32'h7d);
    check_eq("ww_thr1", dut_thr(1), 32'h05f01);

    // Simultaneous 011 in the label cycle, late spike[2] with changed timestamps
    do_reset();
    set_ts_all('h90);
    model_train(0, 0);
    sb_push();
    do_label(3'b001, 3'b011, 0, 3'b100, 3, 'h10, dc);
    sb_drain("sim");

    // Random sequence, state carried between runs
    do_reset();
    for (int it = 0; it < 4; it++) begin
      lab_i = $urandom_range(0, 2);
      for (int j = 0; j < NIN; j++) m_ts[j] = $urandom_range(0, 255);
      m_ts[0] = 0;
      m_ts[1] = 255;
      for (int j = 0; j < NIN; j++) bus.i_ts[j*W +: W] = W'(m_ts[j]);
      for (int k = 0; k < NOUT; k++) begin
        m_lv[k] = $urandom_range(0, 'hfffff);
        bus.i_lv[k*TH +: TH] = TH'(m_lv[k]);
      end
      r   = $urandom_range(0, 4);
      spk = (r == 4) ? 3'b000 : (r == 3) ? 3'($urandom_range(1, 7)) : 3'(1 << r);
      off = $urandom_range(0, 6);
      wn  = spk[0] ? 0 : spk[1] ? 1 : spk[2] ? 2 : -1;
      model_train(lab_i, wn);
      sb_push();
      do_label(3'(1 << lab_i), spk, off, 3'b000, 0, -1, dc);
      check_eq("rnd_done_lat", 32'(dc), 32'd10);
      sb_drain($sformatf("rnd%0d", it));
    end

    // Idle spike: threshold bump only with the unsupervised increment enabled
    do_reset();
    bus.i_spike = 3'b010;
    tick();
    bus.i_spike = '0;
    tick();
`ifdef L2T_UNSUP_INC_EN
    m_thr[1] = 'h0603f;
`endif
    sb_push();
    sb_drain("idle_spk");
    check_eq("las_idle", 32'(bus.o_las), 32'd0);

    // End of epochs blocks the label event
    do_reset();
    bus.i_endof_epochs = 1'b1;
    bus.i_label = 3'b001;
    tick();
    bus.i_label = '0;
    tick();
    check_eq("eoe_gas", 32'(bus.o_gas), 32'd0);
    check_eq("eoe_state", 32'(bus.o_state), 32'd0);
    bus.i_endof_epochs = 1'b0;
    tick();

    // Abort mid-window: no update, no done
    set_ts_all('h90);
    bus.i_label = 3'b100;
    tick();
    bus.i_label = '0;
    bus.i_spike = 3'b100;
    tick();
    bus.i_spike = '0;
    tick();
    bus.i_endof_epochs = 1'b1;
    tick();
    check_eq("abort_state", 32'(bus.o_state), 32'd0);
    check_eq("abort_gas", 32'(bus.o_gas), 32'd0);
    bus.i_endof_epochs = 1'b0;
    cnt_done = 0;
    for (int c = 0; c < 12; c++) begin
      if (bus.o_done) cnt_done++;
      tick();
    end
    check_eq("abort_no_done", 32'(cnt_done), 32'd0);
    sb_push();
    sb_drain("abort");

    // Threshold floor reload on the second instance
    bus2.i_lv[0 +: TH] = TH'('h00123);
    bus2.i_label = 3'b001;
    tick();
    bus2.i_label = '0;
    dc = -1;
    for (int c = 1; c < 40; c++) begin
      if (bus2.o_done) begin
        dc = c;
        break;
      end
      tick();
    end
    check_eq("floor_done_lat", 32'(dc), 32'd10);
    check_eq("floor_thr0", 32'(bus2.o_thresholds[0 +: TH]), 32'h00123);
    check_eq("floor_thr1", 32'(bus2.o_thresholds[TH +: TH]), 32'h00001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
